// File: rtl/transmit_pkg.sv
// Shared definitions for the single-wire serial transmitter and its helpers.
package transmit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b0;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/transmit_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the wrap.
module transmit_bit_timer #(
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_early
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt_r == CNT_MAX);

    // tick_early: the tick fires in the following cycle (single-clock periods tick every cycle).
    assign tick_early = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt_r == CNT_PREV);

endmodule

// File: rtl/transmit.sv
// Serial byte transmitter: START, D7..D0, STOP, idle gap, with a one-deep holding register.
module transmit
    import transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       send,
    output logic       txd,
    output logic       transmit_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT * IDLE_BITS) + 1;
    localparam logic [CNT_W-1:0]     GAP_LAST = CNT_W'(IDLE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t             state_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic [DATA_BITS-1:0]  hold_r;
    logic                  hold_valid_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]      gap_cnt_r;
    logic                  txd_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  frame_done_r;

    logic tick_s;
    logic tick_early_s;
    logic accept_s;
    logic gap_end_s;
    logic capture_s;

    transmit_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_r == ST_IDLE),
        .tick       (tick_s),
        .tick_early (tick_early_s)
    );

    assign accept_s  = send && ready_r;
    assign gap_end_s = (state_r == ST_GAP) && tick_s && (gap_cnt_r == GAP_LAST);
    // A send landing exactly on the end of GAP goes straight to the shifter instead.
    assign capture_s = accept_s && (state_r != ST_IDLE) && !gap_end_s;

    // Frame FSM with shifter, holding register and registered line/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= '0;
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            bit_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            txd_r        <= LINE_IDLE;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (capture_s) begin
                hold_r       <= word;
                hold_valid_r <= 1'b1;
                ready_r      <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r <= word;
                        state_r <= ST_START;
                        txd_r   <= START_BIT;
                        busy_r  <= 1'b1;
                    end else begin
                        txd_r  <= LINE_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    busy_r <= 1'b1;
                    if (tick_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= '0;
                        txd_r     <= shift_r[DATA_BITS-1];
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r      <= ST_STOP;
                            txd_r        <= STOP_BIT;
                            frame_done_r <= tick_early_s;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                            shift_r   <= {shift_r[DATA_BITS-2:0], 1'b0};
                            txd_r     <= shift_r[DATA_BITS-2];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= '0;
                        txd_r     <= LINE_IDLE;
                    end else begin
                        frame_done_r <= tick_early_s;
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        if (hold_valid_r) begin
                            shift_r      <= hold_r;
                            hold_valid_r <= 1'b0;
                            ready_r      <= 1'b1;
                            state_r      <= ST_START;
                            txd_r        <= START_BIT;
                        end else if (accept_s) begin
                            shift_r <= word;
                            state_r <= ST_START;
                            txd_r   <= START_BIT;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= LINE_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (tick_s) begin
                        gap_cnt_r <= gap_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= LINE_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign txd            = txd_r;
    assign transmit_ready = ready_r;
    assign busy           = busy_r;
    assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit: one-clk-per-bit and four-clk-per-bit instances, serial decoder scoreboard.
module tb_transmit;

    logic       clk;
    logic       rst1, send1, txd1, ready1, busy1, fd1;
    logic [7:0] word1;
    logic       rst4, send4, txd4, ready4, busy4, fd4;
    logic [7:0] word4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         mon_phase = 0;
    logic [7:0] mon_data  = 8'h00;

    transmit #(.CLKS_PER_BIT(1), .IDLE_BITS(1)) dut1 (
        .clk(clk), .rst(rst1), .word(word1), .send(send1),
        .txd(txd1), .transmit_ready(ready1), .busy(busy1), .frame_done(fd1)
    );

    transmit #(.CLKS_PER_BIT(4), .IDLE_BITS(1)) dut4 (
        .clk(clk), .rst(rst4), .word(word4), .send(send4),
        .txd(txd4), .transmit_ready(ready4), .busy(busy4), .frame_done(fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level of bit period idx of a frame carrying b (0=START, 1..8 data MSB first, 9=STOP, then idle).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0)      return 1'b0;
        else if (idx <= 8) return b[8-idx];
        else if (idx == 9) return 1'b0;
        else               return 1'b1;
    endfunction

    // Scoreboard monitor: decodes txd of the single-clock instance, compares at frame_done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst1) begin
                mon_phase = 0;
                exp_q.delete();
            end else begin
                case (mon_phase)
                    0: begin
                        chk("mon_idle_done", fd1, 0);
                        if (txd1 == 1'b0) begin
                            mon_phase = 1;
                            mon_data  = 8'h00;
                        end
                    end
                    1, 2, 3, 4, 5, 6, 7, 8: begin
                        chk("mon_data_done", fd1, 0);
                        mon_data  = {mon_data[6:0], txd1};
                        mon_phase = mon_phase + 1;
                    end
                    9: begin
                        chk("mon_stop_level", txd1, 0);
                        chk("mon_stop_done", fd1, 1);
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL mon_extra_frame: got %0h expected no frame", mon_data);
                        end else begin
                            chk("mon_byte", mon_data, exp_q.pop_front());
                        end
                        mon_phase = 10;
                    end
                    default: begin
                        chk("mon_gap_level", txd1, 1);
                        mon_phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        rst1 = 1'b1; send1 = 1'b0; word1 = 8'h00;
        rst4 = 1'b1; send4 = 1'b0; word4 = 8'h00;
        step();
        step();
        chk("rst_txd1", txd1, 1);
        chk("rst_ready1", ready1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", fd1, 0);
        chk("rst_txd4", txd4, 1);
        chk("rst_ready4", ready4, 1);
        chk("rst_busy4", busy4, 0);
        rst1 = 1'b0;
        rst4 = 1'b0;
        step();
        step();

        // Single frame 0xA5.
        send1 = 1'b1; word1 = 8'hA5; exp_q.push_back(8'hA5);
        step();
        send1 = 1'b0; word1 = 8'h3E;
        for (int c = 1; c <= 12; c++) begin
            chk("t1_txd", txd1, frame_bit(8'hA5, c - 1));
            chk("t1_done", fd1, (c == 10));
            chk("t1_ready", ready1, 1);
            chk("t1_busy", busy1, (c <= 11));
            step();
        end

        // 0x3C then queued 0xFF; extra sends while full are ignored.
        send1 = 1'b1; word1 = 8'h3C; exp_q.push_back(8'h3C);
        step();
        for (int c = 1; c <= 23; c++) begin
            chk("t2_ready", ready1, !(c >= 2 && c <= 11));
            chk("t2_busy", busy1, (c <= 22));
            chk("t2_txd", txd1, (c <= 11) ? frame_bit(8'h3C, c - 1) : frame_bit(8'hFF, c - 12));
            chk("t2_done", fd1, (c == 10 || c == 21));
            if (c == 1) begin
                send1 = 1'b1; word1 = 8'hFF; exp_q.push_back(8'hFF);
            end else if (c >= 2 && c <= 5) begin
                send1 = 1'b1; word1 = 8'h77;
            end else if (c == 11) begin
                send1 = 1'b1; word1 = 8'h55;
            end else begin
                send1 = 1'b0; word1 = 8'h99;
            end
            step();
        end
        send1 = 1'b0;
        step();

        // Four clocks per bit, 0x81.
        send4 = 1'b1; word4 = 8'h81;
        step();
        send4 = 1'b0; word4 = 8'h00;
        for (int c = 1; c <= 46; c++) begin
            chk("t4_txd", txd4, (c <= 44) ? frame_bit(8'h81, (c - 1) / 4) : 1'b1);
            chk("t4_done", fd4, (c == 40));
            chk("t4_busy", busy4, (c <= 44));
            step();
        end

        // Reset during DATA bit 3 with a byte queued.
        send1 = 1'b1; word1 = 8'h5A; exp_q.push_back(8'h5A);
        step();
        word1 = 8'h33; exp_q.push_back(8'h33);
        step();
        send1 = 1'b0;
        chk("t5_queued", ready1, 0);
        step();
        step();
        step();
        chk("t5_bit3", txd1, frame_bit(8'h5A, 4));
        rst1 = 1'b1;
        step();
        chk("t5_txd", txd1, 1);
        chk("t5_ready", ready1, 1);
        chk("t5_busy", busy1, 0);
        chk("t5_done", fd1, 0);
        rst1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            chk("t5_quiet_txd", txd1, 1);
            chk("t5_quiet_busy", busy1, 0);
        end

        // Back-to-back burst of edge-case bytes.
        begin
            logic [7:0] burst [4];
            burst[0] = 8'h00; burst[1] = 8'h80; burst[2] = 8'h01; burst[3] = 8'hFF;
            for (int i = 0; i < 4; i++) begin
                int n = 0;
                while (!ready1 && n < 50) begin
                    step();
                    n++;
                end
                chk("t6_ready_wait", ready1, 1);
                send1 = 1'b1; word1 = burst[i]; exp_q.push_back(burst[i]);
                step();
                send1 = 1'b0;
            end
        end
        begin
            int n = 0;
            while (busy1 && n < 100) begin
                step();
                n++;
            end
            chk("t6_idle_wait", busy1, 0);
        end
        step();
        step();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
